// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Shift-add multiply and restoring divide on magnitudes, with a sign fix-up at commit.
module mult_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic                  div_by_zero
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*W-1:0] acc_q, acc_d;     // mult: {partial product, multiplier}; div: low half is dividend/quotient
  logic [W-1:0]  opnd_q, opnd_d;    // multiplicand or divisor magnitude
  logic [W-1:0]  rem_q, rem_d;
  logic          is_div_q, is_div_d;
  logic          neg_res_q, neg_res_d;
  logic          neg_rem_q, neg_rem_d;
  logic          b_zero_q, b_zero_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;
  logic          done_q, done_d;
  logic          dbz_q, dbz_d;

  logic          signed_op;
  logic [W-1:0]  a_mag, b_mag;
  logic [W:0]    add_sum;
  logic [W:0]    shifted;
  logic [W:0]    trial;
  logic [2*W-1:0] prod_fix;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    rem_d     = rem_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    b_zero_d  = b_zero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = dbz_q;

    signed_op = (op == OP_MULT) || (op == OP_DIV);
    a_mag     = (signed_op && a[W-1]) ? -a : a;
    b_mag     = (signed_op && b[W-1]) ? -b : b;
    add_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
    shifted   = {rem_q, acc_q[W-1]};
    trial     = shifted - {1'b0, opnd_q};
    prod_fix  = neg_res_q ? -acc_q : acc_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              is_div_d  = op[1];
              acc_d     = {{W{1'b0}}, (op[1] ? a_mag : b_mag)};
              opnd_d    = op[1] ? b_mag : a_mag;
              rem_d     = '0;
              neg_res_d = signed_op & (a[W-1] ^ b[W-1]);
              neg_rem_d = signed_op & a[W-1];
              b_zero_d  = (b == '0);
              cnt_d     = '0;
              dbz_d     = 1'b0;
              state_d   = S_RUN;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (is_div_q) begin
          // Restoring step: keep the trial difference only when it did not go negative.
          if (!trial[W]) begin
            rem_d          = trial[W-1:0];
            acc_d[W-1:0]   = {acc_q[W-2:0], 1'b1};
          end else begin
            rem_d          = shifted[W-1:0];
            acc_d[W-1:0]   = {acc_q[W-2:0], 1'b0};
          end
        end else begin
          acc_d = {add_sum, acc_q[W-1:1]};
        end
        if (cnt_q == CW'(W - 1)) begin
          state_d = S_FINISH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FINISH: begin
        if (is_div_q) begin
          if (b_zero_q) begin
            dbz_d = 1'b1;
          end else begin
            lo_d = neg_res_q ? -acc_q[W-1:0] : acc_q[W-1:0];
            hi_d = neg_rem_q ? -rem_q : rem_q;
          end
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      rem_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      b_zero_q  <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      rem_q     <= rem_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      b_zero_q  <= b_zero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed cases plus randomized ops against an arithmetic model of HI/LO.
module tb_mult_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  int checks;
  int failures;

  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic        m_dbz;

  mult_div_unit #(.DATA_WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero and % follows the dividend.
  task automatic model_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, p, q, r;
    logic [63:0] up;
    case (o)
      3'd0: begin
        p = longint'($signed(x)) * longint'($signed(y));
        m_hi = p[63:32]; m_lo = p[31:0]; m_dbz = 1'b0;
      end
      3'd1: begin
        up = {32'd0, x} * {32'd0, y};
        m_hi = up[63:32]; m_lo = up[31:0]; m_dbz = 1'b0;
      end
      3'd2: begin
        if (y == 32'd0) m_dbz = 1'b1;
        else begin
          sx = longint'($signed(x)); sy = longint'($signed(y));
          q = sx / sy; r = sx % sy;
          m_lo = q[31:0]; m_hi = r[31:0]; m_dbz = 1'b0;
        end
      end
      3'd3: begin
        if (y == 32'd0) m_dbz = 1'b1;
        else begin
          m_lo = x / y; m_hi = x % y; m_dbz = 1'b0;
        end
      end
      3'd4: m_hi = x;
      3'd5: m_lo = x;
      default: ;
    endcase
  endtask

  // Called at a falling edge with the unit idle; returns at the falling edge of the done cycle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input string name);
    int lat;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL %s busy_after_accept got=%b want=1", name, busy); end
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (lat == 16) begin
        checks++;
        if (hi !== m_hi || lo !== m_lo) begin
          failures++;
          $display("FAIL %s hilo_stable_in_run got=%h_%h want=%h_%h", name, hi, lo, m_hi, m_lo);
        end
      end
    end
    model_op(o, x, y);
    checks++;
    if (lat != 33) begin failures++; $display("FAIL %s latency got=%0d want=33", name, lat); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL %s busy_at_done got=%b want=0", name, busy); end
    checks++;
    if (hi !== m_hi) begin failures++; $display("FAIL %s hi got=%h want=%h (a=%h b=%h op=%0d)", name, hi, m_hi, x, y, o); end
    checks++;
    if (lo !== m_lo) begin failures++; $display("FAIL %s lo got=%h want=%h (a=%h b=%h op=%0d)", name, lo, m_lo, x, y, o); end
    checks++;
    if (div_by_zero !== m_dbz) begin failures++; $display("FAIL %s div_by_zero got=%b want=%b", name, div_by_zero, m_dbz); end
  endtask

  // Called at a falling edge with the unit idle; returns one cycle later at a falling edge.
  task automatic do_move(input logic [2:0] o, input logic [31:0] x, input string name);
    start = 1'b1; op = o; a = x; b = $urandom;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    model_op(o, x, 32'd0);
    checks++;
    if (hi !== m_hi || lo !== m_lo) begin
      failures++; $display("FAIL %s hilo got=%h_%h want=%h_%h", name, hi, lo, m_hi, m_lo);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL %s busy_done got=%b%b want=00", name, busy, done);
    end
  endtask

  task automatic test_reset;
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_values got hi=%h lo=%h busy=%b done=%b dbz=%b want all zero", hi, lo, busy, done, div_by_zero);
    end
    m_hi = 32'd0; m_lo = 32'd0; m_dbz = 1'b0;
  endtask

  task automatic test_directed;
    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, "mult_neg");
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
      failures++; $display("FAIL mult_neg_const got=%h_%h want=ffffffff_fffffffa", hi, lo);
    end
    @(negedge clk);
    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, "multu");
    checks++;
    if (hi !== 32'h0000_0002 || lo !== 32'hFFFF_FFFA) begin
      failures++; $display("FAIL multu_const got=%h_%h want=00000002_fffffffa", hi, lo);
    end
    @(negedge clk);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, "div_neg");
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      failures++; $display("FAIL div_neg_const got=%h_%h want=ffffffff_fffffffd", hi, lo);
    end
    @(negedge clk);
    run_op(3'd3, 32'd7, 32'd2, "divu");
    checks++;
    if (hi !== 32'd1 || lo !== 32'd3) begin
      failures++; $display("FAIL divu_const got=%h_%h want=00000001_00000003", hi, lo);
    end
    @(negedge clk);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_by_m1");
    checks++;
    if (hi !== 32'd0 || lo !== 32'h8000_0000) begin
      failures++; $display("FAIL div_min_by_m1_const got=%h_%h want=00000000_80000000", hi, lo);
    end
    @(negedge clk);
  endtask

  task automatic test_div_by_zero;
    do_move(3'd5, 32'h1234_5678, "mtlo");
    do_move(3'd4, 32'h0000_ABCD, "mthi");
    start = 1'b1; op = 3'd6; a = 32'hDEAD_BEEF; b = 32'd1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (hi !== 32'h0000_ABCD || lo !== 32'h1234_5678 || busy !== 1'b0) begin
      failures++; $display("FAIL noop_op got=%h_%h busy=%b want=0000abcd_12345678 busy=0", hi, lo, busy);
    end
    run_op(3'd3, 32'd99, 32'd0, "divu_by_zero");
    checks++;
    if (done !== 1'b1 || div_by_zero !== 1'b1 || hi !== 32'h0000_ABCD || lo !== 32'h1234_5678) begin
      failures++;
      $display("FAIL dbz_const got done=%b dbz=%b %h_%h want 1 1 0000abcd_12345678", done, div_by_zero, hi, lo);
    end
    @(negedge clk);
    checks++;
    if (div_by_zero !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL dbz_hold got dbz=%b done=%b want dbz=1 done=0", div_by_zero, done);
    end
  endtask

  task automatic test_reset_abort;
    logic seen;
    start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL ignored_start got busy=%b done=%b want busy=1 done=0", busy, done);
    end
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_abort got hi=%h lo=%h busy=%b done=%b dbz=%b want all zero", hi, lo, busy, done, div_by_zero);
    end
    rst_n = 1'b1;
    m_hi = 32'd0; m_lo = 32'd0; m_dbz = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      failures++; $display("FAIL no_done_after_reset got seen=%b hi=%h lo=%h want 0 0 0", seen, hi, lo);
    end
  endtask

  task automatic test_back_to_back;
    run_op(3'd1, 32'd5, 32'd7, "b2b_multu");
    checks++;
    if (lo !== 32'd35 || hi !== 32'd0) begin
      failures++; $display("FAIL b2b_multu_const got=%h_%h want=00000000_00000023", hi, lo);
    end
    run_op(3'd3, 32'd100, 32'd7, "b2b_divu");
    checks++;
    if (lo !== 32'd14 || hi !== 32'd2) begin
      failures++; $display("FAIL b2b_divu_const got=%h_%h want=00000002_0000000e", hi, lo);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL done_single_cycle got=%b want=0", done); end
  endtask

  task automatic test_random;
    logic [2:0]  o;
    logic [31:0] x, y;
    for (int i = 0; i < 30; i++) begin
      o = 3'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 2) == 0) y = 32'($urandom_range(1, 20));
      if ($urandom_range(0, 3) == 0) y = -y;
      if ($urandom_range(0, 6) == 0) y = 32'd0;
      if ($urandom_range(0, 6) == 0) x = 32'h8000_0000;
      run_op(o, x, y, "random");
      if ($urandom_range(0, 1) == 0) @(negedge clk);
      if ($urandom_range(0, 4) == 0) do_move(3'($urandom_range(4, 5)), $urandom, "random_move");
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    m_hi = 32'd0; m_lo = 32'd0; m_dbz = 1'b0;
    rst_n = 1'b0; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset;
    test_directed;
    test_div_by_zero;
    test_reset_abort;
    test_back_to_back;
    @(negedge clk);
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
